// File: rtl/mux_scan_n.sv
// Parametrised N-to-1 mux with registered output, direct select and auto-scan sweep.
// Optional channel mask port and skip logic enabled by defining MUX_SCAN_MASK_EN.
module mux_scan_n #(
   parameter int unsigned WIDTH    = 1,
   parameter int unsigned CHANNELS = 16,
   parameter int unsigned SEL_W    = 4,
   parameter int unsigned DWELL    = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH*CHANNELS-1:0] in,
   input  logic [SEL_W-1:0]          sel,
   input  logic                      mode,
   input  logic                      hold,
`ifdef MUX_SCAN_MASK_EN
   input  logic [CHANNELS-1:0]       mask,
`endif
   output logic [WIDTH-1:0]          out,
   output logic [SEL_W-1:0]          out_sel,
   output logic                      out_valid,
   output logic                      wrap
);

   typedef enum logic {ST_DIRECT, ST_SCAN} state_t;

   state_t            state_q, state_d;
   logic [SEL_W-1:0]  ptr_q, ptr_d;
   logic [7:0]        dwell_q, dwell_d;
   logic              pend_q, pend_d;
   logic [WIDTH-1:0]  out_q, out_d;
   logic [SEL_W-1:0]  osel_q, osel_d;
   logic              valid_q, valid_d;
   logic              wrap_q, wrap_d;

   logic [CHANNELS-1:0] en;
   logic                any_en;
   logic                sel_ok;
   logic [SEL_W-1:0]    hi_ch;
   logic [SEL_W-1:0]    nxt_ch;
   logic                nxt_wrap;

`ifdef MUX_SCAN_MASK_EN
   assign en = mask;
`else
   assign en = '1;
`endif

   assign any_en = |en;

   function automatic logic [WIDTH-1:0] pick(input logic [WIDTH*CHANNELS-1:0] bus,
                                             input logic [SEL_W-1:0] idx);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (32'(idx) == k) r = bus[k*WIDTH +: WIDTH];
      end
      return r;
   endfunction

   // Select legality, highest enabled channel, and the next lower enabled
   // channel measured as descending distance from ptr (distance CHANNELS = itself).
   always_comb begin
      int unsigned best_d;
      int unsigned d;
      sel_ok   = 1'b0;
      hi_ch    = '0;
      nxt_ch   = ptr_q;
      nxt_wrap = 1'b0;
      best_d   = CHANNELS + 1;
      for (int unsigned k = 0; k < CHANNELS; k++) begin
         if (32'(sel) == k) sel_ok = en[k];
         if (en[k]) begin
            hi_ch = SEL_W'(k);
            if (32'(ptr_q) > k) d = 32'(ptr_q) - k;
            else                d = 32'(ptr_q) + CHANNELS - k;
            if (d < best_d) begin
               best_d   = d;
               nxt_ch   = SEL_W'(k);
               nxt_wrap = (k >= 32'(ptr_q));
            end
         end
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      dwell_d = dwell_q;
      pend_d  = 1'b0;
      out_d   = '0;
      osel_d  = sel;
      valid_d = 1'b0;
      wrap_d  = 1'b0;
      if (state_q == ST_SCAN && mode) begin
         osel_d  = ptr_q;
         valid_d = any_en;
         wrap_d  = pend_q;
         if (any_en) out_d = pick(in, ptr_q);
         if (!hold && any_en) begin
            if (dwell_q == 8'(DWELL - 1)) begin
               dwell_d = '0;
               ptr_d   = nxt_ch;
               pend_d  = nxt_wrap;
            end else begin
               dwell_d = dwell_q + 8'd1;
            end
         end
      end else begin
         valid_d = sel_ok;
         if (sel_ok) out_d = pick(in, sel);
         state_d = mode ? ST_SCAN : ST_DIRECT;
         if (mode) begin
            ptr_d   = hi_ch;
            dwell_d = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_DIRECT;
         ptr_q   <= SEL_W'(CHANNELS - 1);
         dwell_q <= '0;
         pend_q  <= 1'b0;
         out_q   <= '0;
         osel_q  <= '0;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         dwell_q <= dwell_d;
         pend_q  <= pend_d;
         out_q   <= out_d;
         osel_q  <= osel_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign out       = out_q;
   assign out_sel   = osel_q;
   assign out_valid = valid_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_mux_scan_n.sv
// Bench for mux_scan_n: sweep position derived from a count of advancing scan cycles.
module tb_mux_scan_n;
   localparam int W  = 2;
   localparam int CH = 12;
   localparam int SW = 4;
   localparam int DW = 3;

   logic            clk = 1'b0;
   logic            reset;
   logic [W*CH-1:0] in_v;
   logic [SW-1:0]   sel;
   logic            mode;
   logic            hold;
   logic [W-1:0]    out;
   logic [SW-1:0]   out_sel;
   logic            out_valid;
   logic            wrap;

   always #5 clk = ~clk;

   mux_scan_n #(.WIDTH(W), .CHANNELS(CH), .SEL_W(SW), .DWELL(DW)) dut (
      .clk(clk), .reset(reset), .in(in_v), .sel(sel), .mode(mode), .hold(hold),
      .out(out), .out_sel(out_sel), .out_valid(out_valid), .wrap(wrap));

   int checks   = 0;
   int failures = 0;

   int  e_out, e_sel;
   bit  e_val, e_wrap;
   bit  m_scan;
   int  adv;
   bit  prev_inc;
   bit  cmp_en = 1'b0;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at time %0t", name, act, exp, $time);
      end
   endtask

   function automatic int chan(input logic [W*CH-1:0] d, input int idx);
      return int'(d[idx*W +: W]);
   endfunction

   // Sweep position is adv/DW steps down from CH-1; wrap follows a step into a new period.
   task automatic model_edge();
      if (reset) begin
         e_out = 0; e_sel = 0; e_val = 0; e_wrap = 0;
         m_scan = 0; adv = 0; prev_inc = 0;
      end else if (!m_scan || !mode) begin
         e_sel  = int'(sel);
         e_val  = (int'(sel) < CH);
         e_out  = e_val ? chan(in_v, int'(sel)) : 0;
         e_wrap = 0;
         if (mode) begin
            adv = 0;
            prev_inc = 0;
         end
         m_scan = mode;
      end else begin
         e_sel  = CH - 1 - ((adv / DW) % CH);
         e_val  = 1;
         e_out  = chan(in_v, e_sel);
         e_wrap = prev_inc && (adv > 0) && (adv % (CH*DW) == 0);
         if (!hold) begin
            adv++;
            prev_inc = 1;
         end else begin
            prev_inc = 0;
         end
      end
   endtask

   task automatic step(input logic r, input logic [SW-1:0] s, input logic m,
                       input logic h, input logic [W*CH-1:0] d);
      reset = r; sel = s; mode = m; hold = h; in_v = d;
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (cmp_en) begin
         check("out",       int'(out),       e_out);
         check("out_sel",   int'(out_sel),   e_sel);
         check("out_valid", int'(out_valid), int'(e_val));
         check("wrap",      int'(wrap),      int'(e_wrap));
      end
   end

   initial begin
      logic [W*CH-1:0] d;
      logic            m;
      int w1, w2, cnt9;
      cmp_en = 1'b1;

      step(1'b1, 4'd0, 1'b1, 1'b0, '1);
      step(1'b1, 4'd0, 1'b1, 1'b0, '1);
      check("rst_out",   int'(out), 0);
      check("rst_valid", int'(out_valid), 0);
      check("rst_sel",   int'(out_sel), 0);
      check("rst_wrap",  int'(wrap), 0);

      step(1'b0, 4'd0, 1'b0, 1'b0, '1);
      check("direct0_out",   int'(out), 3);
      check("direct0_valid", int'(out_valid), 1);

      step(1'b0, 4'd13, 1'b0, 1'b0, '1);
      check("oor_out",   int'(out), 0);
      check("oor_valid", int'(out_valid), 0);
      check("oor_sel",   int'(out_sel), 13);
      step(1'b0, 4'd11, 1'b0, 1'b0, '1);
      check("sel11_valid", int'(out_valid), 1);
      check("sel11_out",   int'(out), 3);

      d = 24'hA5A5A5;
      step(1'b0, 4'd5, 1'b1, 1'b0, d);
      check("entry_sel", int'(out_sel), 5);
      w1 = 0; w2 = 0;
      for (int n = 1; n <= 73; n++) begin
         step(1'b0, 4'd5, 1'b1, 1'b0, d);
         if (n == 1) begin
            check("sweep_first_sel", int'(out_sel), 11);
            check("sweep_first_out", int'(out), 2);
         end
         if (wrap) begin
            if (w1 == 0) w1 = n;
            else if (w2 == 0) w2 = n;
         end
      end
      check("wrap_first",  w1, 37);
      check("wrap_second", w2, 73);

      step(1'b0, 4'd5, 1'b0, 1'b0, d);
      step(1'b0, 4'd5, 1'b1, 1'b0, d);
      cnt9 = 0;
      for (int n = 1; n <= 15; n++) begin
         step(1'b0, 4'd5, 1'b1, (n >= 8 && n <= 12), d);
         if (out_sel == 4'd9) cnt9++;
         if (n == 7)  check("hold_start_sel", int'(out_sel), 9);
         if (n == 15) check("hold_after_sel", int'(out_sel), 8);
      end
      check("hold_cnt9", cnt9, 8);

      step(1'b1, 4'd2, 1'b1, 1'b0, d);
      check("midrst_out",   int'(out), 0);
      check("midrst_valid", int'(out_valid), 0);
      check("midrst_sel",   int'(out_sel), 0);
      step(1'b0, 4'd2, 1'b1, 1'b0, d);
      check("postrst_sel",   int'(out_sel), 2);
      check("postrst_out",   int'(out), 2);
      check("postrst_valid", int'(out_valid), 1);

      m = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(127) == 0) m = ~m;
         step(($urandom_range(63) == 0), 4'($urandom_range(15)), m,
              ($urandom_range(3) == 0), 24'($urandom));
      end

      cmp_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
